// File: rtl/multibyte_add_sequencer.sv
// rtl/multibyte_add_sequencer.sv - NBYTES-wide add/sub sequenced through one shared 8-bit adder
// Bytes are processed LSB first; the inter-byte carry lives only in carry_reg.
module multibyte_add_sequencer #(
   parameter int NBYTES = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_sub,
   input  logic [8*NBYTES-1:0] req_a,
   input  logic [8*NBYTES-1:0] req_b,
   output logic [7:0]          add_a,
   output logic [7:0]          add_b,
   output logic                add_cin,
   input  logic [7:0]          add_sum,
   input  logic                add_cout,
   output logic                resp_valid,
   input  logic                resp_ready,
   output logic [8*NBYTES-1:0] result,
   output logic                carry_out,
   output logic                overflow,
   output logic                zero
);

   localparam int W    = 8 * NBYTES;
   localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t          state;
   state_t          state_next;
   logic [W-1:0]    a_reg;
   logic [W-1:0]    b_reg;
   logic [W-1:0]    result_reg;
   logic [IDXW-1:0] idx;
   logic            carry_reg;
   logic            carry_out_reg;
   logic            overflow_reg;
   logic            accept;
   logic            last_byte;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      add_a      = 8'h00;
      add_b      = 8'h00;
      add_cin    = 1'b0;
      accept     = 1'b0;
      last_byte  = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               accept     = 1'b1;
               state_next = RUN;
            end
         end
         RUN: begin
            add_a   = a_reg[8*idx +: 8];
            add_b   = b_reg[8*idx +: 8];
            add_cin = carry_reg;
            if (idx == LAST_IDX) begin
               last_byte  = 1'b1;
               state_next = DONE;
            end
         end
         DONE: begin
            resp_valid = 1'b1;
            if (resp_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // b_reg holds B already inverted for subtraction; the +1 enters as the initial carry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_reg         <= '0;
         b_reg         <= '0;
         result_reg    <= '0;
         idx           <= '0;
         carry_reg     <= 1'b0;
         carry_out_reg <= 1'b0;
         overflow_reg  <= 1'b0;
      end else if (accept) begin
         a_reg     <= req_a;
         b_reg     <= req_sub ? ~req_b : req_b;
         carry_reg <= req_sub;
         idx       <= '0;
      end else if (state == RUN) begin
         result_reg[8*idx +: 8] <= add_sum;
         carry_reg              <= add_cout;
         if (last_byte) begin
            carry_out_reg <= add_cout;
            overflow_reg  <= (a_reg[W-1] == b_reg[W-1]) && (add_sum[7] != a_reg[W-1]);
         end else begin
            idx <= idx + IDXW'(1);
         end
      end
   end

   assign result    = result_reg;
   assign carry_out = carry_out_reg;
   assign overflow  = overflow_reg;
   assign zero      = (result_reg == '0);

endmodule

// File: tb/tb_multibyte_add_sequencer.sv
// tb/tb_multibyte_add_sequencer.sv - scoreboard bench for multibyte_add_sequencer
// Expected responses come from whole-word arithmetic, not byte-serial emulation.
module tb_multibyte_add_sequencer;

   localparam int NB = 4;
   localparam int W  = 8 * NB;
   localparam longint SMAX = 64'sd2147483647;
   localparam longint SMIN = -64'sd2147483648;

   typedef struct packed {
      logic [W-1:0] result;
      logic         carry;
      logic         ovf;
      logic         zero;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         req_valid;
   logic         req_ready;
   logic         req_sub;
   logic [W-1:0] req_a;
   logic [W-1:0] req_b;
   logic [7:0]   add_a;
   logic [7:0]   add_b;
   logic         add_cin;
   logic [7:0]   add_sum;
   logic         add_cout;
   logic         resp_valid;
   logic         resp_ready;
   logic [W-1:0] result;
   logic         carry_out;
   logic         overflow;
   logic         zero;
   logic [8:0]   add_full;

   int   checks = 0;
   int   passes = 0;
   exp_t exp_q[$];
   logic [7:0] first_add_b;
   logic       first_add_cin;

   always #5 clk = ~clk;

   // The shared external 8-bit adder
   assign add_full = {1'b0, add_a} + {1'b0, add_b} + {8'h00, add_cin};
   assign add_sum  = add_full[7:0];
   assign add_cout = add_full[8];

   multibyte_add_sequencer #(.NBYTES(NB)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_sub(req_sub),
      .req_a(req_a), .req_b(req_b),
      .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
      .add_sum(add_sum), .add_cout(add_cout),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .result(result), .carry_out(carry_out), .overflow(overflow), .zero(zero)
   );

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      checks++;
      if (act === req) passes++;
      else $display("FAIL %s: got %h required %h", name, act, req);
   endtask

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
      exp_t   e;
      longint sa, sb, sr, ua, ub;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'h0, a});
      ub = longint'({32'h0, b});
      if (sub) begin
         e.result = a - b;
         e.carry  = (a >= b);
         sr       = sa - sb;
      end else begin
         e.result = a + b;
         e.carry  = ((ua + ub) > 64'sd4294967295);
         sr       = sa + sb;
      end
      e.ovf  = (sr > SMAX) || (sr < SMIN);
      e.zero = (e.result == '0);
      return e;
   endfunction

   // Monitor: compares every completed response handshake against the scoreboard head
   always @(negedge clk) begin
      if (rst_n && resp_valid && resp_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_resp", 1, 0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("result", result, e.result);
            check("carry_out", carry_out, e.carry);
            check("overflow", overflow, e.ovf);
            check("zero", zero, e.zero);
         end
      end
   end

   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub, input int hold);
      exp_t e;
      int   k;
      req_a = a; req_b = b; req_sub = sub; req_valid = 1'b1;
      k = 0;
      while (!req_ready && k < 20) begin
         @(posedge clk); #1; k++;
      end
      check("accept_ready", req_ready, 1);
      @(posedge clk);
      e = model(a, b, sub);
      exp_q.push_back(e);
      #1;
      first_add_b   = add_b;
      first_add_cin = add_cin;
      // Junk on the request port while busy must be ignored
      req_valid = 1'($urandom_range(0, 1));
      req_a = $urandom; req_b = $urandom; req_sub = 1'($urandom_range(0, 1));
      check("run_req_ready", req_ready, 0);
      k = 0;
      while (!resp_valid && k < NB + 4) begin
         @(posedge clk); #1; k++;
      end
      check("latency", k, NB);
      check("done_adder_idle", {add_a, add_b, add_cin}, 0);
      for (int i = 0; i < hold; i++) begin
         req_valid = 1'b1;
         check("bp_req_ready", req_ready, 0);
         check("bp_resp_valid", resp_valid, 1);
         check("bp_result", result, e.result);
         check("bp_carry", carry_out, e.carry);
         check("bp_overflow", overflow, e.ovf);
         @(posedge clk); #1;
      end
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      check("hs_resp_valid", resp_valid, 0);
      check("hs_req_ready", req_ready, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] ra, rb;
      rst_n = 1'b0; req_valid = 1'b0; req_sub = 1'b0; req_a = '0; req_b = '0; resp_ready = 1'b0;
      #12;
      check("rst_req_ready", req_ready, 1);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_result", result, 0);
      check("rst_flags", {carry_out, overflow}, 0);
      check("rst_adder", {add_a, add_b, add_cin}, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      do_op(32'h000000FF, 32'h00000001, 1'b0, 0);
      do_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1);
      do_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 0);
      do_op(32'h80000000, 32'h00000001, 1'b1, 2);
      do_op(32'h00000005, 32'h00000007, 1'b1, 0);
      check("borrow_first_cin", first_add_cin, 1);
      check("borrow_first_add_b", first_add_b, 8'hF8);
      do_op(32'h12345678, 32'h0000FFFF, 1'b0, 3);

      // Reset while RUN is on byte 2
      req_a = 32'h11223344; req_b = 32'h01010101; req_sub = 1'b0; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("mid_run_byte2", add_a, 8'h22);
      rst_n = 1'b0;
      #1;
      check("mid_rst_req_ready", req_ready, 1);
      check("mid_rst_resp_valid", resp_valid, 0);
      check("mid_rst_result", result, 0);
      check("mid_rst_flags", {carry_out, overflow}, 0);
      check("mid_rst_adder", {add_a, add_b, add_cin}, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < NB + 2; i++) begin
         @(posedge clk); #1;
         check("post_rst_no_resp", resp_valid, 0);
      end
      do_op(32'h00000010, 32'h00000020, 1'b0, 0);

      for (int n = 0; n < 30; n++) begin
         case ($urandom_range(0, 3))
            0: ra = 32'h80000000;
            1: ra = 32'h7FFFFFFF;
            default: ra = $urandom;
         endcase
         rb = ($urandom_range(0, 4) == 0) ? ra : $urandom;
         do_op(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
      end

      repeat (3) @(posedge clk);
      #1;
      check("scoreboard_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
